// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier sequencer.
// The control bundle groups the datapath strobes for reuse at the top level.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        ADD,
        SHIFT,
        DONE
    } booth_state_t;

    // {Q[0], Q[-1]} patterns that require an adder cycle
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef struct packed {
        logic load_a;
        logic load_b;
        logic load_add;
        logic add_sub;
        logic shift;
    } booth_ctrl_t;

    function automatic logic needs_addsub(input logic [1:0] pair);
        return (pair == BOOTH_ADD) || (pair == BOOTH_SUB);
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: rise is high while d is high and was low
// at the previous clock edge.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/booth_sequencer.sv
// Control FSM stepping a radix-2 Booth datapath through load, add/sub and
// shift for N iterations, with abort and a sticky result-valid flag.
module booth_sequencer
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] q_lsb,
    output logic       load_a,
    output logic       load_b,
    output logic       load_add,
    output logic       add_sub,
    output logic       shift,
    output logic       busy,
    output logic       done,
    output logic       result_valid
);

    localparam int CW = $clog2(N + 1);

    booth_state_t state_reg;
    booth_state_t state_next;
    logic [CW-1:0] cnt_reg;
    logic          add_sub_reg;
    logic          result_valid_reg;
    logic          start_rise;
    booth_ctrl_t   ctrl;

    edge_detect u_start_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (start),
        .rise (start_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            unique case (state_reg)
                IDLE:    if (start_rise) state_next = LOAD;
                LOAD:    state_next = CHECK;
                CHECK:   state_next = needs_addsub(q_lsb) ? ADD : SHIFT;
                ADD:     state_next = SHIFT;
                SHIFT:   state_next = (cnt_reg == CW'(1)) ? DONE : CHECK;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Iteration counter, operation latch for the adder, and the sticky valid flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg          <= '0;
            add_sub_reg      <= 1'b0;
            result_valid_reg <= 1'b0;
        end else if (abort) begin
            cnt_reg          <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            unique case (state_reg)
                IDLE:    if (start_rise) result_valid_reg <= 1'b0;
                LOAD:    cnt_reg <= CW'(N);
                CHECK:   add_sub_reg <= (q_lsb == BOOTH_ADD);
                SHIFT:   cnt_reg <= cnt_reg - CW'(1);
                DONE:    result_valid_reg <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ctrl         = '0;
        ctrl.add_sub = add_sub_reg;
        busy         = (state_reg != IDLE);
        done         = (state_reg == DONE);
        unique case (state_reg)
            LOAD: begin
                ctrl.load_a = 1'b1;
                ctrl.load_b = 1'b1;
            end
            ADD:     ctrl.load_add = 1'b1;
            SHIFT:   ctrl.shift    = 1'b1;
            default: ;
        endcase
    end

    assign load_a       = ctrl.load_a;
    assign load_b       = ctrl.load_b;
    assign load_add     = ctrl.load_add;
    assign add_sub      = ctrl.add_sub;
    assign shift        = ctrl.shift;
    assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_booth_sequencer.sv
// Directed bench for booth_sequencer with a behavioural 8-bit Booth datapath
// for end-to-end product checks.
module tb_booth_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] q_lsb;
    logic       load_a, load_b, load_add, add_sub, shift, busy, done, result_valid;

    booth_sequencer #(.N(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .q_lsb        (q_lsb),
        .load_a       (load_a),
        .load_b       (load_b),
        .load_add     (load_add),
        .add_sub      (add_sub),
        .shift        (shift),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    logic [7:0] outs;
    assign outs = {load_a, load_b, load_add, add_sub, shift, busy, done, result_valid};

    // Behavioural datapath; HQ carries one guard bit so -128 * -128 does not overflow
    logic [7:0] a_in = '0, b_in = '0, a_r = '0, lq = '0;
    logic [8:0] hq = '0;
    logic       qm1 = 1'b0;
    logic       use_dp = 1'b0;
    logic [1:0] q_force = 2'b00;
    logic [15:0] y_dp;

    always @(posedge clk) begin
        if (load_a) a_r <= a_in;
        if (load_b) begin
            lq  <= b_in;
            hq  <= '0;
            qm1 <= 1'b0;
        end else if (load_add) begin
            hq <= add_sub ? hq + {a_r[7], a_r} : hq - {a_r[7], a_r};
        end else if (shift) begin
            {hq, lq, qm1} <= {hq[8], hq, lq};
        end
    end

    assign y_dp  = {hq[7:0], lq};
    assign q_lsb = use_dp ? {lq[0], qm1} : q_force;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    int r_load, r_load_cyc, r_shift, r_add, r_sub, r_done, r_done_cyc, r_busy, r_overlap, r_rv_after;
    logic [15:0] r_y;

    // Issues one start edge, then observes ncyc cycles (cycle 1 = first after the accepting edge)
    task automatic run_op(input logic [1:0] qv, input bit dp, input int ncyc, input bit hold,
                          input int restart_at, input int abort_at, input int rst_at);
        q_force = qv;
        use_dp  = dp;
        r_load = 0; r_load_cyc = -1; r_shift = 0; r_add = 0; r_sub = 0;
        r_done = 0; r_done_cyc = -1; r_busy = 0; r_overlap = 0; r_rv_after = -1;
        r_y = '0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            if (load_a) begin
                r_load++;
                if (r_load_cyc < 0) r_load_cyc = i;
            end
            if (shift) r_shift++;
            if (load_add) begin
                if (add_sub) r_add++;
                else r_sub++;
            end
            if (int'(load_a) + int'(load_add) + int'(shift) > 1) r_overlap++;
            if (busy) r_busy++;
            if (done) begin
                r_done++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = i;
                    r_y = y_dp;
                end
            end
            if (r_done_cyc > 0 && i == r_done_cyc + 1) r_rv_after = int'(result_valid);
            if (i == rst_at) begin
                check("shift_before_rst", 32'(shift), 32'd1);
                rst = 1'b0;
                #1;
                check("async_rst_outs", 32'(outs), 32'd0);
            end
            if (rst_at > 0 && i == rst_at + 1) rst = 1'b1;
            abort = (i == abort_at);
            start = hold || (i == restart_at);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // Reset held for three cycles
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outs_low", 32'(outs), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_outs", 32'(outs), 32'd0);

        // No add: q_lsb = 00 every CHECK
        run_op(2'b00, 1'b0, 30, 1'b0, 0, 0, 0);
        check("noadd_load_cyc", r_load_cyc, 1);
        check("noadd_shifts", r_shift, 8);
        check("noadd_addsub", r_add + r_sub, 0);
        check("noadd_done_cyc", r_done_cyc, 18);
        check("noadd_busy_cycles", r_busy, 18);
        check("noadd_rv_after", r_rv_after, 1);
        check("noadd_overlap", r_overlap, 0);
        check("rv_sticky", 32'(result_valid), 32'd1);

        // All add (01) then all subtract (10)
        run_op(2'b01, 1'b0, 30, 1'b0, 0, 0, 0);
        check("add_pulses_plus", r_add, 8);
        check("add_pulses_minus", r_sub, 0);
        check("add_done_cyc", r_done_cyc, 26);
        check("add_shifts", r_shift, 8);
        check("add_overlap", r_overlap, 0);
        run_op(2'b10, 1'b0, 30, 1'b0, 0, 0, 0);
        check("sub_pulses_minus", r_sub, 8);
        check("sub_pulses_plus", r_add, 0);
        check("sub_done_cyc", r_done_cyc, 26);

        // Reset in the SHIFT of iteration 4 (cycle 9 when no adds occur)
        run_op(2'b00, 1'b0, 14, 1'b0, 0, 0, 9);
        check("rst_mid_no_done", r_done, 0);
        check("rst_mid_idle_outs", 32'(outs), 32'd0);

        // Abort in cycle 7
        run_op(2'b00, 1'b0, 30, 1'b0, 0, 7, 0);
        check("abort_busy_cycles", r_busy, 7);
        check("abort_no_done", r_done, 0);
        check("abort_rv", 32'(result_valid), 32'd0);

        // Complete one op so result_valid is set, then abort during DONE
        run_op(2'b00, 1'b0, 30, 1'b0, 0, 0, 0);
        run_op(2'b00, 1'b0, 30, 1'b0, 0, 18, 0);
        check("abort_done_pulse", r_done, 1);
        check("abort_done_rv_after", r_rv_after, 0);

        // Abort coincident with a start edge in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        check("abort_start_busy", 32'(busy), 32'd0);
        check("abort_start_no_load", 32'(load_a), 32'd0);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_start_still_idle", 32'(busy), 32'd0);
        start = 1'b0;

        // Start held high for 60 cycles
        run_op(2'b00, 1'b0, 60, 1'b1, 0, 0, 0);
        check("hold_loads", r_load, 1);
        check("hold_dones", r_done, 1);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Second start edge during CHECK is ignored
        run_op(2'b00, 1'b0, 40, 1'b0, 2, 0, 0);
        check("restart_loads", r_load, 1);
        check("restart_dones", r_done, 1);

        // Integration with the datapath model
        a_in = 8'd5;   b_in = 8'hFD;
        run_op(2'b00, 1'b1, 30, 1'b0, 0, 0, 0);
        check("mul_5_m3", r_y, 32'hFFF1);
        a_in = 8'h80;  b_in = 8'h80;
        run_op(2'b00, 1'b1, 30, 1'b0, 0, 0, 0);
        check("mul_m128_m128", r_y, 32'h4000);
        a_in = 8'd0;   b_in = 8'd127;
        run_op(2'b00, 1'b1, 30, 1'b0, 0, 0, 0);
        check("mul_0_127", r_y, 32'h0000);
        check("mul_0_127_done", r_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/booth_sequencer.md
# booth_sequencer

Control FSM that sequences the radix-2 Booth multiplier datapath (the `mult_with_no_fsm` instance) between the number-entry logic and the display path. It accepts a start request once both operands are latched and steps the datapath through load, conditional add/subtract and arithmetic shift for N iterations. It then reports completion and holds a result-valid flag that selects the product for the BCD/display mux. Keypad activity can abort an operation in progress.

## Interface
Parameters:
- `N`, default 8: operand width and iteration count; legal N ≥ 2.

Ports:
- `clk`, input, 1: system clock; one clock domain.
- `rst`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: operands ready, from the number-entry block. Edge-qualified internally.
- `abort`, input, 1: synchronous cancel, from new keypad entry.
- `q_lsb`, input, 2: {Q[0], Q[-1]} from the datapath.
- `load_a`, output, 1: load multiplicand register.
- `load_b`, output, 1: load multiplier/Q register, clear HQ and Q[-1].
- `load_add`, output, 1: write the adder result into HQ.
- `add_sub`, output, 1: 1 = HQ + A, 0 = HQ − A. Meaningful only while `load_add` = 1.
- `shift`, output, 1: arithmetic right shift of {HQ, LQ, Q[-1]}.
- `busy`, output, 1: state ≠ IDLE.
- `done`, output, 1: single-cycle completion pulse.
- `result_valid`, output, 1: product valid; drives the display select.

## Operation
- Start acceptance: `start_q` registers `start`. A start is accepted only when state = IDLE and `start & ~start_q`.
  - A `start` held high triggers exactly one operation.
  - A `start` edge while busy is ignored, not queued.
- States:
  - **IDLE**: all strobes 0. On accepted start → LOAD, clear `result_valid`.
  - **LOAD** (1 cycle): `load_a` = `load_b` = 1, `cnt` ← N → CHECK.
  - **CHECK** (1 cycle): no strobes. Registers `add_sub` ← (`q_lsb` == 2'b01).
    - `q_lsb` = 01 or 10 → ADD.
    - `q_lsb` = 00 or 11 → SHIFT.
  - **ADD** (1 cycle): `load_add` = 1 → SHIFT.
  - **SHIFT** (1 cycle): `shift` = 1, `cnt` ← `cnt` − 1. If `cnt` == 1 → DONE, else → CHECK.
  - **DONE** (1 cycle): `done` = 1, `result_valid` ← 1 → IDLE.
- Output decoding:
  - Strobes are Moore outputs decoded from the state register only.
  - `add_sub` is a register held stable from CHECK through ADD.
- `cnt` width: $clog2(N+1). It never wraps: the exit from SHIFT happens at `cnt` == 1.
- `abort` handling:
  - In any state, `abort` = 1 → IDLE at the next edge.
  - No `done` pulse is produced; `result_valid` ← 0 and `cnt` ← 0.
  - `abort` and a start edge in the same cycle: abort wins and the start is dropped.
  - `abort` during DONE: `done` is still high that cycle, but `result_valid` ends 0.
- `result_valid` is cleared only by an accepted start, `abort` or reset.
- Reset (`rst` = 0, asynchronous): state IDLE; `cnt`, `start_q` and `add_sub` = 0; all outputs 0. This applies immediately, including mid-operation.

## Timing
- Edge E0 samples an accepted start. LOAD occupies cycle 1.
- Each iteration takes 2 cycles (CHECK, SHIFT) or 3 cycles (with ADD).
- `done` is high in cycle 2N+2+K, where K = number of add/sub iterations (0 ≤ K ≤ N).
  - For N = 8: minimum 18 cycles, maximum 26 cycles.
- `result_valid` rises at the edge ending DONE, i.e. it is visible from cycle 2N+3+K.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- `q_lsb` is sampled only in CHECK. The datapath must present Q[0]/Q[-1] updated by the previous `shift` or load. One cycle after SHIFT/LOAD is sufficient because the datapath registers update on the same edge that enters CHECK.
- Exactly N `shift` pulses and K `load_add` pulses occur per completed operation. Strobes are never asserted in overlapping cycles.

## Structure
- Shared package `booth_pkg`:
  - `typedef enum logic [2:0] {IDLE, LOAD, CHECK, ADD, SHIFT, DONE} booth_state_t`
  - Constants `BOOTH_ADD = 2'b01` and `BOOTH_SUB = 2'b10`.
  - Control bundle struct `booth_ctrl_t` {load_a, load_b, load_add, add_sub, shift}, for reuse by the top level.
- One sub-module, `edge_detect`: registered rising-edge detector for `start`, async active-low reset. Everything else stays in one module.

## Test plan
- **Reset**: `rst` low 3 cycles, then high with `start` = 0. All outputs 0 and state IDLE. Reassert `rst` in SHIFT of iteration 4: outputs go to 0 asynchronously, before the next edge.
- **No-add case**: N = 8, bench holds `q_lsb` = 00 at every CHECK. Expect 8 `shift` pulses, 0 `load_add`, `done` in cycle 18, `result_valid` = 1 from cycle 19.
- **All-add case**: `q_lsb` = 01 at every CHECK. Expect 8 `load_add` pulses, each with `add_sub` = 1, `done` in cycle 26. Then with `q_lsb` = 10 at every CHECK: 8 pulses with `add_sub` = 0.
- **Abort**:
  - Assert `abort` in cycle 7: `busy` = 0 in cycle 8, no `done`, `result_valid` = 0.
  - Abort coincident with a start edge in IDLE: no LOAD follows.
- **Start protocol**: hold `start` high 60 cycles → exactly one LOAD and one `done`. Issue a second start edge during CHECK → ignored, no extra `done`.
- **Integration** with `mult_with_no_fsm #(8)`:
  - a = 5, b = −3 → y = 16'hFFF1 at `done`.
  - a = −128, b = −128 → y = 16'h4000.
  - a = 0, b = 127 → y = 0.
